lieat_axi_sram_slave: RTL and testbench
=======================================

Name:
lieat_axi_sram_slave

Overview:
- Single-beat AXI-style responder (slave) that sits at the far end of the dcache_axi channel set driven by the data cache.
- Serves AR/R and AW/W/B transactions from an internal word-organised SRAM model, with programmable read and write latency.
- Used as the memory side in core-level simulation and in the SoC fabric stub.
- No bursts, no IDs, one outstanding read plus one outstanding write.

Parameters:
- XLEN, 32, data/address width.
- ADDR_BASE, 32'h8000_0000, byte address of word 0.
- DEPTH_LOG2, 12, log2 of SRAM depth in 32-bit words (default 16 KiB).
- RD_LAT, 1, extra wait cycles before R data (0..15).
- WR_LAT, 1, extra wait cycles before B response (0..15).

Ports:
- clk  in  1  clock
- rstn  in  1  asynchronous active-low reset
- dcache_axi_arvalid  in  1  read address valid
- dcache_axi_arready  out  1  read address ready
- dcache_axi_araddr  in  XLEN  read byte address
- dcache_axi_arsize  in  3  read size (0 byte, 1 half, 2 word)
- dcache_axi_rvalid  out  1  read data valid
- dcache_axi_rready  in  1  read data ready
- dcache_axi_rdata  out  XLEN  read data (full aligned word)
- dcache_axi_awvalid  in  1  write address valid
- dcache_axi_awready  out  1  write address ready
- dcache_axi_awaddr  in  XLEN  write byte address
- dcache_axi_awsize  in  3  write size
- dcache_axi_wvalid  in  1  write data valid
- dcache_axi_wready  out  1  write data ready
- dcache_axi_wdata  in  XLEN  write data, lane-aligned to awaddr[1:0]
- dcache_axi_bvalid  out  1  write response valid
- dcache_axi_bready  in  1  write response ready
- dcache_axi_bresp  out  2  2'b00 OKAY, 2'b10 SLVERR

Behaviour:
- Reset (async, rstn=0): read FSM R_IDLE, write FSM W_ACCEPT, aw_got=w_got=0, rvalid=0, bvalid=0, rdata=0, bresp=0. SRAM contents are not reset. Any in-flight transaction is dropped.
- Read FSM, states R_IDLE → R_WAIT → R_RESP:
  - arready = (state==R_IDLE).
  - On the AR handshake: latch araddr/arsize, load rcnt=RD_LAT, go to R_WAIT.
  - R_WAIT: if rcnt!=0, decrement. Else sample the SRAM word at araddr[DEPTH_LOG2+1:2] into rdata, set rvalid=1, go to R_RESP.
  - rvalid therefore rises RD_LAT+1 cycles after the handshake cycle.
  - R_RESP: rvalid and rdata are held stable until rready=1, then rvalid=0 and the FSM returns to R_IDLE. No new AR is accepted in the same cycle.
  - Out-of-range read (addr-ADDR_BASE ≥ 4<<DEPTH_LOG2, or addr<ADDR_BASE): rdata=0, normal timing.
  - arsize is ignored for reads; the slave always returns the aligned word.
- Write FSM, states W_ACCEPT → W_WAIT → W_RESP:
  - AW and W are accepted independently, in either order or in the same cycle.
  - awready = W_ACCEPT & ~aw_got; wready = W_ACCEPT & ~w_got. Each handshake latches its payload and sets its got flag.
  - When both flags are set, load wcnt=WR_LAT and go to W_WAIT. The same-cycle case (both handshakes in one cycle) transfers directly.
  - W_WAIT: if wcnt!=0, decrement. Else commit the write, set bvalid=1 and bresp, go to W_RESP.
  - bvalid therefore rises WR_LAT+1 cycles after the later of the two handshakes.
  - W_RESP: hold until bready=1, then clear bvalid, aw_got and w_got, and return to W_ACCEPT.
- Byte enables, from awsize and awaddr[1:0]:
  - size 0: 4'b0001<<a.
  - size 1: 4'b0011<<a, a[0] must be 0.
  - size 2: 4'b1111, a must be 0.
  - Only the enabled lanes of wdata are written.
- Write errors: misalignment, size>2, or out-of-range → no SRAM update, bresp=2'b10. Otherwise bresp=2'b00.
- A read sample and a write commit to the same word in the same cycle: the read returns the pre-write data.
- Read and write paths are fully concurrent; neither FSM stalls the other.

Test Plan:
- Write a word: AW 0x8000_0010/size2 and W 0x1234_5678 in the same cycle, bready=1, WR_LAT=1 → bvalid 2 cycles later with bresp=00. Then AR 0x8000_0010 → rvalid 2 cycles after the handshake, rdata=0x1234_5678.
- Byte and half writes: write 0xAABBCCDD to 0x8000_0020, then byte 0x0000_EE00 at 0x8000_0021 and half 0x1122_0000 at 0x8000_0022 → read returns 0x1122EEDD.
- Order independence: W three cycles before AW → awready and wready each drop after their own handshake; exactly one B is returned, with correct data.
- Errors: word write to 0x8000_0002 → bresp=10, memory unchanged. Write at 0x8000_4000 (DEPTH_LOG2=12) → bresp=10. Read at 0x7FFF_FFFC → rdata=0.
- Backpressure: hold rready=0 and bready=0 for 5 cycles → rvalid, rdata, bvalid and bresp stay stable; arready=0 throughout; completion occurs in the cycle ready rises.
- Reset mid-read: assert rstn=0 in R_WAIT → rvalid=0 immediately and arready=1 after release. Previously written data is still readable.

Source files
------------

// File: rtl/lieat_axi_sram_slave.sv
// Single-beat AXI-style SRAM responder on the dcache_axi channel set.
// One outstanding read and one outstanding write, each with its own FSM and
// a programmable wait count before the response beat.
module lieat_axi_sram_slave #(
  parameter int unsigned     XLEN       = 32,
  parameter logic [XLEN-1:0] ADDR_BASE  = 32'h8000_0000,
  parameter int unsigned     DEPTH_LOG2 = 12,
  parameter int unsigned     RD_LAT     = 1,
  parameter int unsigned     WR_LAT     = 1
) (
  input  logic            clk,
  input  logic            rstn,
  input  logic            dcache_axi_arvalid,
  output logic            dcache_axi_arready,
  input  logic [XLEN-1:0] dcache_axi_araddr,
  input  logic [2:0]      dcache_axi_arsize,
  output logic            dcache_axi_rvalid,
  input  logic            dcache_axi_rready,
  output logic [XLEN-1:0] dcache_axi_rdata,
  input  logic            dcache_axi_awvalid,
  output logic            dcache_axi_awready,
  input  logic [XLEN-1:0] dcache_axi_awaddr,
  input  logic [2:0]      dcache_axi_awsize,
  input  logic            dcache_axi_wvalid,
  output logic            dcache_axi_wready,
  input  logic [XLEN-1:0] dcache_axi_wdata,
  output logic            dcache_axi_bvalid,
  input  logic            dcache_axi_bready,
  output logic [1:0]      dcache_axi_bresp
);

  localparam int unsigned     DEPTH  = 1 << DEPTH_LOG2;
  localparam logic [XLEN-1:0] SPAN   = XLEN'(DEPTH * 4);
  localparam logic [3:0]      RD_CNT = 4'(RD_LAT);
  localparam logic [3:0]      WR_CNT = 4'(WR_LAT);

  typedef enum logic [1:0] {R_IDLE, R_WAIT, R_RESP} r_state_e;
  typedef enum logic [1:0] {W_ACCEPT, W_WAIT, W_RESP} w_state_e;

  // Word-organised storage; deliberately not reset.
  logic [XLEN-1:0] mem [DEPTH];

  // Address hits the SRAM window (below-base and past-the-end both miss).
  function automatic logic in_range(input logic [XLEN-1:0] addr);
    logic [XLEN-1:0] off;
    off = addr - ADDR_BASE;
    return (addr >= ADDR_BASE) && (off < SPAN);
  endfunction

  // Read size is not needed: the full aligned word is always returned.
  logic unused_arsize;
  assign unused_arsize = ^dcache_axi_arsize;

  // ---------------------------------------------------------------- read path
  r_state_e        r_state_q, r_state_d;
  logic [XLEN-1:0] raddr_q, raddr_d;
  logic [3:0]      rcnt_q, rcnt_d;
  logic [XLEN-1:0] rdata_q, rdata_d;
  logic            rvalid_q, rvalid_d;
  logic [DEPTH_LOG2-1:0] ridx;

  assign ridx               = raddr_q[DEPTH_LOG2+1:2];
  assign dcache_axi_arready = (r_state_q == R_IDLE);
  assign dcache_axi_rvalid  = rvalid_q;
  assign dcache_axi_rdata   = rdata_q;

  // Read FSM next state: accept AR, count down, sample SRAM, hold until rready.
  always_comb begin
    r_state_d = r_state_q;
    raddr_d   = raddr_q;
    rcnt_d    = rcnt_q;
    rdata_d   = rdata_q;
    rvalid_d  = rvalid_q;
    case (r_state_q)
      R_IDLE: begin
        if (dcache_axi_arvalid) begin
          raddr_d   = dcache_axi_araddr;
          rcnt_d    = RD_CNT;
          r_state_d = R_WAIT;
        end
      end
      R_WAIT: begin
        if (rcnt_q != 4'd0) begin
          rcnt_d = rcnt_q - 4'd1;
        end else begin
          rdata_d   = in_range(raddr_q) ? mem[ridx] : '0;
          rvalid_d  = 1'b1;
          r_state_d = R_RESP;
        end
      end
      R_RESP: begin
        if (dcache_axi_rready) begin
          rvalid_d  = 1'b0;
          r_state_d = R_IDLE;
        end
      end
      default: r_state_d = R_IDLE;
    endcase
  end

  // Read FSM registers.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      r_state_q <= R_IDLE;
      raddr_q   <= '0;
      rcnt_q    <= '0;
      rdata_q   <= '0;
      rvalid_q  <= 1'b0;
    end else begin
      r_state_q <= r_state_d;
      raddr_q   <= raddr_d;
      rcnt_q    <= rcnt_d;
      rdata_q   <= rdata_d;
      rvalid_q  <= rvalid_d;
    end
  end

  // --------------------------------------------------------------- write path
  w_state_e        w_state_q, w_state_d;
  logic            aw_got_q, aw_got_d;
  logic            w_got_q, w_got_d;
  logic [XLEN-1:0] awaddr_q, awaddr_d;
  logic [2:0]      awsize_q, awsize_d;
  logic [XLEN-1:0] wdata_q, wdata_d;
  logic [3:0]      wcnt_q, wcnt_d;
  logic            bvalid_q, bvalid_d;
  logic [1:0]      bresp_q, bresp_d;
  logic [3:0]      wbe;
  logic            werr;
  logic            mem_we;
  logic [DEPTH_LOG2-1:0] widx;

  assign widx               = awaddr_q[DEPTH_LOG2+1:2];
  assign dcache_axi_awready = (w_state_q == W_ACCEPT) && !aw_got_q;
  assign dcache_axi_wready  = (w_state_q == W_ACCEPT) && !w_got_q;
  assign dcache_axi_bvalid  = bvalid_q;
  assign dcache_axi_bresp   = bresp_q;

  // Byte enables and error decode from the latched size/address.
  always_comb begin
    wbe  = 4'b0000;
    werr = 1'b0;
    case (awsize_q)
      3'd0: wbe = 4'b0001 << awaddr_q[1:0];
      3'd1: begin
        wbe  = 4'b0011 << awaddr_q[1:0];
        werr = awaddr_q[0];
      end
      3'd2: begin
        wbe  = 4'b1111;
        werr = |awaddr_q[1:0];
      end
      default: werr = 1'b1;
    endcase
    if (!in_range(awaddr_q)) werr = 1'b1;
  end

  // Write FSM next state: collect AW and W in any order, count down, commit.
  always_comb begin
    w_state_d = w_state_q;
    aw_got_d  = aw_got_q;
    w_got_d   = w_got_q;
    awaddr_d  = awaddr_q;
    awsize_d  = awsize_q;
    wdata_d   = wdata_q;
    wcnt_d    = wcnt_q;
    bvalid_d  = bvalid_q;
    bresp_d   = bresp_q;
    mem_we    = 1'b0;
    case (w_state_q)
      W_ACCEPT: begin
        if (dcache_axi_awvalid && dcache_axi_awready) begin
          awaddr_d = dcache_axi_awaddr;
          awsize_d = dcache_axi_awsize;
          aw_got_d = 1'b1;
        end
        if (dcache_axi_wvalid && dcache_axi_wready) begin
          wdata_d = dcache_axi_wdata;
          w_got_d = 1'b1;
        end
        if (aw_got_d && w_got_d) begin
          wcnt_d    = WR_CNT;
          w_state_d = W_WAIT;
        end
      end
      W_WAIT: begin
        if (wcnt_q != 4'd0) begin
          wcnt_d = wcnt_q - 4'd1;
        end else begin
          mem_we    = !werr;
          bvalid_d  = 1'b1;
          bresp_d   = werr ? 2'b10 : 2'b00;
          w_state_d = W_RESP;
        end
      end
      W_RESP: begin
        if (dcache_axi_bready) begin
          bvalid_d  = 1'b0;
          aw_got_d  = 1'b0;
          w_got_d   = 1'b0;
          w_state_d = W_ACCEPT;
        end
      end
      default: w_state_d = W_ACCEPT;
    endcase
  end

  // Write FSM registers.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      w_state_q <= W_ACCEPT;
      aw_got_q  <= 1'b0;
      w_got_q   <= 1'b0;
      awaddr_q  <= '0;
      awsize_q  <= '0;
      wdata_q   <= '0;
      wcnt_q    <= '0;
      bvalid_q  <= 1'b0;
      bresp_q   <= 2'b00;
    end else begin
      w_state_q <= w_state_d;
      aw_got_q  <= aw_got_d;
      w_got_q   <= w_got_d;
      awaddr_q  <= awaddr_d;
      awsize_q  <= awsize_d;
      wdata_q   <= wdata_d;
      wcnt_q    <= wcnt_d;
      bvalid_q  <= bvalid_d;
      bresp_q   <= bresp_d;
    end
  end

  // SRAM lane writes; a same-cycle read sample still sees the old word.
  always_ff @(posedge clk) begin
    for (int i = 0; i < 4; i++) begin
      if (mem_we && wbe[i]) mem[widx][8*i +: 8] <= wdata_q[8*i +: 8];
    end
  end

endmodule

// File: tb/tb_lieat_axi_sram_slave.sv
// Scoreboard bench for lieat_axi_sram_slave: expected R data / B responses
// are queued when a transaction is issued and popped when the beat arrives.
module tb_lieat_axi_sram_slave;
  localparam logic [31:0] BASE = 32'h8000_0000;
  localparam int RDL = 1;
  localparam int WRL = 1;

  logic        clk = 1'b0;
  logic        rstn = 1'b0;
  logic        arvalid = 0, arready, rvalid, rready = 0;
  logic [31:0] araddr = 0, rdata;
  logic [2:0]  arsize = 0;
  logic        awvalid = 0, awready, wvalid = 0, wready, bvalid, bready = 0;
  logic [31:0] awaddr = 0, wdata = 0;
  logic [2:0]  awsize = 0;
  logic [1:0]  bresp;

  int n_vec = 0;
  int n_bad = 0;
  logic [31:0] rq [$];
  logic [1:0]  bq [$];
  logic [31:0] model [int];

  always #5 clk = ~clk;

  lieat_axi_sram_slave dut (
    .clk(clk), .rstn(rstn),
    .dcache_axi_arvalid(arvalid), .dcache_axi_arready(arready),
    .dcache_axi_araddr(araddr), .dcache_axi_arsize(arsize),
    .dcache_axi_rvalid(rvalid), .dcache_axi_rready(rready),
    .dcache_axi_rdata(rdata),
    .dcache_axi_awvalid(awvalid), .dcache_axi_awready(awready),
    .dcache_axi_awaddr(awaddr), .dcache_axi_awsize(awsize),
    .dcache_axi_wvalid(wvalid), .dcache_axi_wready(wready),
    .dcache_axi_wdata(wdata),
    .dcache_axi_bvalid(bvalid), .dcache_axi_bready(bready),
    .dcache_axi_bresp(bresp)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: got %08h want %08h", tag, obs, exp);
    end
  endtask

  // Reference memory as bit masks; returns the expected bresp.
  function automatic logic [1:0] model_wr(input logic [31:0] a, input logic [2:0] sz,
                                          input logic [31:0] d);
    logic [31:0] mask;
    int w;
    if (a < BASE || (a - BASE) >= 32'h4000) return 2'b10;
    case (sz)
      3'd0: mask = 32'hFF << (8 * a[1:0]);
      3'd1: begin
        if (a[0]) return 2'b10;
        mask = 32'hFFFF << (8 * a[1:0]);
      end
      3'd2: begin
        if (a[1:0] != 2'b00) return 2'b10;
        mask = 32'hFFFF_FFFF;
      end
      default: return 2'b10;
    endcase
    w = int'((a - BASE) >> 2);
    if (!model.exists(w)) model[w] = 32'h0;
    model[w] = (model[w] & ~mask) | (d & mask);
    return 2'b00;
  endfunction

  function automatic logic [31:0] model_rd(input logic [31:0] a);
    int w;
    w = int'((a - BASE) >> 2);
    if (a < BASE || (a - BASE) >= 32'h4000 || !model.exists(w)) return 32'h0;
    return model[w];
  endfunction

  // W is presented w_lead cycles before AW; hold = cycles bready stays low after bvalid.
  task automatic axi_wr(input logic [31:0] a, input logic [2:0] sz, input logic [31:0] d,
                        input int w_lead, input int hold);
    logic aw_done, w_done, aw_hs, w_hs;
    logic [1:0] exp;
    int cyc, lat;
    aw_done = 0; w_done = 0; cyc = 0; lat = 0;
    bq.push_back(model_wr(a, sz, d));
    bready = (hold == 0);
    awaddr = a; awsize = sz; wdata = d;
    wvalid = 1'b1;
    awvalid = (w_lead == 0);
    while (!(aw_done && w_done) && cyc < 40) begin
      aw_hs = awvalid && awready;
      w_hs  = wvalid && wready;
      @(negedge clk); cyc++;
      if (aw_hs) begin aw_done = 1; awvalid = 0; end
      if (w_hs)  begin w_done = 1;  wvalid = 0;  end
      if (!aw_done) begin
        if (w_done) chk("wready_after_w", wready, 0);
        if (cyc >= w_lead) awvalid = 1'b1;
      end
    end
    awvalid = 0; wvalid = 0;
    chk("aw_w_accepted", {30'd0, aw_done, w_done}, 32'd3);
    chk("awready_after_aw", awready, 0);
    while (!bvalid && lat < 40) begin @(negedge clk); lat++; end
    chk("b_latency", lat, WRL + 1);
    exp = bq.pop_front();
    chk("bresp", bresp, exp);
    for (int i = 0; i < hold; i++) begin
      @(negedge clk);
      chk("b_hold_valid", bvalid, 1);
      chk("b_hold_resp", bresp, exp);
    end
    bready = 1'b1;
    @(negedge clk);
    chk("b_complete", bvalid, 0);
    chk("awready_back", awready, 1);
    @(negedge clk);
    chk("b_single", bvalid, 0);
  endtask

  // hold = cycles rready stays low after rvalid.
  task automatic axi_rd(input logic [31:0] a, input logic [31:0] exp_in, input int hold);
    logic [31:0] exp;
    int cyc, lat;
    cyc = 0; lat = 0;
    rq.push_back(exp_in);
    rready = (hold == 0);
    araddr = a; arsize = 3'd2; arvalid = 1'b1;
    while (!arready && cyc < 40) begin @(negedge clk); cyc++; end
    @(negedge clk);
    arvalid = 1'b0;
    chk("arready_after_ar", arready, 0);
    while (!rvalid && lat < 40) begin @(negedge clk); lat++; end
    chk("r_latency", lat, RDL + 1);
    exp = rq.pop_front();
    chk("rdata", rdata, exp);
    for (int i = 0; i < hold; i++) begin
      @(negedge clk);
      chk("r_hold_valid", rvalid, 1);
      chk("r_hold_data", rdata, exp);
      chk("r_hold_arready", arready, 0);
    end
    rready = 1'b1;
    @(negedge clk);
    chk("r_complete", rvalid, 0);
    chk("arready_back", arready, 1);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    repeat (3) @(negedge clk);
    chk("rst_arready", arready, 1);
    chk("rst_awready", awready, 1);
    chk("rst_wready", wready, 1);
    chk("rst_rvalid", rvalid, 0);
    chk("rst_bvalid", bvalid, 0);
    chk("rst_rdata", rdata, 0);
    chk("rst_bresp", bresp, 0);
    rstn = 1'b1;
    @(negedge clk);

    // Word write then read back.
    axi_wr(32'h8000_0010, 3'd2, 32'h1234_5678, 0, 0);
    axi_rd(32'h8000_0010, 32'h1234_5678, 0);

    // Byte and half merges.
    axi_wr(32'h8000_0020, 3'd2, 32'hAABB_CCDD, 0, 0);
    axi_wr(32'h8000_0021, 3'd0, 32'h0000_EE00, 0, 0);
    axi_wr(32'h8000_0022, 3'd1, 32'h1122_0000, 0, 0);
    axi_rd(32'h8000_0020, 32'h1122_EEDD, 0);
    axi_wr(32'h8000_0023, 3'd0, 32'h5500_0000, 0, 0);
    axi_rd(32'h8000_0020, model_rd(32'h8000_0020), 0);

    // W ahead of AW.
    axi_wr(32'h8000_0030, 3'd2, 32'hCAFE_F00D, 3, 0);
    axi_rd(32'h8000_0030, model_rd(32'h8000_0030), 0);

    // Error responses leave memory untouched.
    axi_wr(32'h8000_0000, 3'd2, 32'h0BAD_F00D, 0, 0);
    axi_wr(32'h8000_0002, 3'd2, 32'hFFFF_FFFF, 0, 0);
    axi_wr(32'h8000_0001, 3'd1, 32'hFFFF_FFFF, 0, 0);
    axi_wr(32'h8000_0000, 3'd3, 32'hFFFF_FFFF, 0, 0);
    axi_rd(32'h8000_0000, 32'h0BAD_F00D, 0);
    axi_wr(32'h8000_4000, 3'd2, 32'h1111_1111, 0, 0);
    axi_rd(32'h7FFF_FFFC, 32'h0, 0);
    axi_rd(32'h8000_4000, 32'h0, 0);
    axi_wr(32'h8000_3FFC, 3'd2, 32'h600D_CAFE, 0, 0);
    axi_rd(32'h8000_3FFC, 32'h600D_CAFE, 0);

    // Backpressure on both response channels.
    axi_wr(32'h8000_0040, 3'd2, 32'hDEAD_BEEF, 0, 5);
    axi_rd(32'h8000_0040, 32'hDEAD_BEEF, 5);

    // Reset while the read is counting down.
    rready = 1'b1;
    araddr = 32'h8000_0010; arvalid = 1'b1;
    @(negedge clk);
    arvalid = 1'b0;
    chk("mid_arready", arready, 0);
    rstn = 1'b0;
    #1;
    chk("mid_rst_rvalid", rvalid, 0);
    @(negedge clk);
    rstn = 1'b1;
    @(negedge clk);
    chk("mid_rel_arready", arready, 1);
    repeat (4) @(negedge clk);
    chk("mid_dropped", rvalid, 0);
    axi_rd(32'h8000_0010, 32'h1234_5678, 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
